// File: rtl/button_event.sv
// Classifies a debounced button level into press, release, short, long and held events.
// Define BTN_REPEAT_EN to compile in the auto-repeat counter and repeat_pulse output.
module button_event #(
   parameter int LONG_CYCLES = 50000000
`ifdef BTN_REPEAT_EN
   ,
   parameter int REPEAT_CYCLES = 10000000
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic dbin,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_press,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);

   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [HW-1:0] LONG_V = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] ONE_V  = HW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      LONG  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          dbin_q, dbin_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          short_q, short_d;
   logic          long_q, long_d;
   logic          held_q, held_d;

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      dbin_d    = dbin;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (dbin && !dbin_q) begin
               state_d = PRESS;
               hold_d  = ONE_V;
               press_d = 1'b1;
            end
         end
         PRESS: begin
            if (!dbin) begin
               state_d   = IDLE;
               hold_d    = '0;
               release_d = 1'b1;
               short_d   = 1'b1;
            end else if (hold_q + ONE_V == LONG_V) begin
               state_d = LONG;
               hold_d  = LONG_V;
               long_d  = 1'b1;
            end else begin
               hold_d = hold_q + ONE_V;
            end
         end
         LONG: begin
            // The hold count stays saturated here; only a fall leaves LONG.
            if (!dbin) begin
               state_d   = IDLE;
               hold_d    = '0;
               release_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
      held_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dbin_q    <= 1'b0;
         hold_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dbin_q    <= dbin_d;
         hold_q    <= hold_d;
         press_q   <= press_d;
         release_q <= release_d;
         short_q   <= short_d;
         long_q    <= long_d;
         held_q    <= held_d;
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign short_press   = short_q;
   assign long_press    = long_q;
   assign held          = held_q;

`ifdef BTN_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_q, rep_d;
   logic          repeat_q, repeat_d;

   // Counts high samples spent in LONG; the counter is zero on entry, so the
   // first pulse lands REPEAT_CYCLES samples after long_press.
   always_comb begin
      rep_d    = '0;
      repeat_d = 1'b0;
      if (state_q == LONG && dbin) begin
         if (rep_q == REP_LAST) begin
            repeat_d = 1'b1;
         end else begin
            rep_d = rep_q + RW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q    <= '0;
         repeat_q <= 1'b0;
      end else begin
         rep_q    <= rep_d;
         repeat_q <= repeat_d;
      end
   end

   assign repeat_pulse = repeat_q;
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: directed vector table, reset corner cases,
// and random press runs checked against an arithmetic reference model.
module tb_button_event;

   localparam int LONG = 8;
   localparam int REP  = 3;
`ifdef BTN_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic dbin;
   logic press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;

   int checks = 0;
   int errors = 0;

   // Reference model state: active press flag, previous sample, unsaturated hold count
   bit         mActive;
   bit         mPrev;
   int         mHold;
   logic [5:0] mExp;

   typedef struct {
      logic       d;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[$];

   button_event #(
      .LONG_CYCLES(LONG)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_CYCLES(REP)
`endif
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .dbin(dbin),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .short_press(short_press),
      .long_press(long_press),
      .repeat_pulse(repeat_pulse),
      .held(held)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      mActive = 1'b0;
      mPrev   = 1'b0;
      mHold   = 0;
      mExp    = '0;
   endtask

   // Expected outputs ordered {press, release, short, long, repeat, held}
   task automatic modelStep(input logic d);
      logic p, r, s, l, rp;
      p  = 1'b0;
      r  = 1'b0;
      s  = 1'b0;
      l  = 1'b0;
      rp = 1'b0;
      if (d) begin
         if (!mActive) begin
            if (!mPrev) begin
               mActive = 1'b1;
               mHold   = 1;
               p       = 1'b1;
            end
         end else begin
            mHold = mHold + 1;
            l  = (mHold == LONG);
            rp = REP_EN && (mHold > LONG) && (((mHold - LONG) % REP) == 0);
         end
      end else if (mActive) begin
         r       = 1'b1;
         s       = (mHold < LONG);
         mActive = 1'b0;
         mHold   = 0;
      end
      mPrev = d;
      mExp  = {p, r, s, l, rp, mActive};
   endtask

   task automatic applyStimulus(input logic d);
      dbin = d;
      modelStep(d);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [5:0] exp);
      logic [5:0] act;
      act = {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got {prs,rel,sht,lng,rep,hld}=%b expected %b at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic addVec(input logic d, input logic [5:0] e);
      vec_t v;
      v.d   = d;
      v.exp = e;
      vecs.push_back(v);
   endtask

   initial begin
      int repCount;
      int ones;
      int zeros;

      rst_n = 1'b0;
      dbin  = 1'b0;
      modelReset();

      for (int i = 0; i < 6; i++) begin
         dbin = logic'(i % 2);
         @(posedge clk);
         #1;
         checkOutput("reset_hold", 6'b000000);
      end

      @(negedge clk);
      dbin  = 1'b0;
      rst_n = 1'b1;
      modelReset();
      applyStimulus(1'b0);
      checkOutput("idle_after_reset", 6'b000000);

      // Short press of 3 samples
      addVec(1'b1, 6'b100001);
      addVec(1'b1, 6'b000001);
      addVec(1'b1, 6'b000001);
      addVec(1'b0, 6'b011000);
      addVec(1'b0, 6'b000000);
      // Alternating 1,0,1,0
      addVec(1'b1, 6'b100001);
      addVec(1'b0, 6'b011000);
      addVec(1'b1, 6'b100001);
      addVec(1'b0, 6'b011000);
      addVec(1'b0, 6'b000000);
      // LONG-1 high samples is still short
      addVec(1'b1, 6'b100001);
      for (int i = 0; i < LONG - 2; i++) addVec(1'b1, 6'b000001);
      addVec(1'b0, 6'b011000);
      addVec(1'b0, 6'b000000);
      // Exactly LONG high samples is long
      addVec(1'b1, 6'b100001);
      for (int i = 0; i < LONG - 2; i++) addVec(1'b1, 6'b000001);
      addVec(1'b1, 6'b000101);
      addVec(1'b0, 6'b010000);
      addVec(1'b0, 6'b000000);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].d);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      end

      // 17-sample hold: long at 8, repeats at 11, 14, 17 when enabled
      repCount = 0;
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(1'b1);
         checkOutput($sformatf("repeat_h%0d", i),
                     {i == 1, 1'b0, 1'b0, i == LONG,
                      REP_EN && (i == 11 || i == 14 || i == 17), 1'b1});
         if (repeat_pulse === 1'b1) repCount++;
      end
      checks++;
      if (repCount != (REP_EN ? 3 : 0)) begin
         errors++;
         $display("[TB] FAIL repeat_count: got %0d expected %0d", repCount, REP_EN ? 3 : 0);
      end
      applyStimulus(1'b0);
      checkOutput("repeat_release", 6'b010000);
      applyStimulus(1'b0);

      // Reset asserted asynchronously at H=5
      for (int i = 1; i <= 5; i++) applyStimulus(1'b1);
      checkOutput("pre_reset_h5", 6'b000001);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 6'b000000);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checkOutput("reset_mid_press", 6'b000000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      applyStimulus(1'b1);
      checkOutput("press_after_reset", 6'b100001);
      applyStimulus(1'b0);
      checkOutput("release_after_reset", 6'b011000);

      // Random press runs against the reference model
      for (int r = 0; r < 80; r++) begin
         ones  = $urandom_range(1, 20);
         zeros = $urandom_range(1, 3);
         for (int i = 0; i < ones; i++) begin
            applyStimulus(1'b1);
            checkOutput("random_high", mExp);
         end
         for (int i = 0; i < zeros; i++) begin
            applyStimulus(1'b0);
            checkOutput("random_low", mExp);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
